word_to_byte_serializer: RTL and testbench



---
 rtl/word_to_byte_serializer.sv | 77 +++++++
 tb/tb_word_to_byte_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/word_to_byte_serializer.sv
// Word-to-byte serializer: one WIDTH-bit word in, NBYTES bytes out MSB first.
// A frame's last flag rides on the final byte of the word that carried it.
module word_to_byte_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       data_out,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             last_q;

    logic fin;
    logic in_xfer;
    logic out_xfer;

    assign fin       = (cnt_q == LAST_CNT);
    assign data_out  = shreg_q[WIDTH-1:WIDTH-8];
    assign out_valid = (state_q == BUSY);
    assign out_last  = (state_q == BUSY) & last_q & fin;
    assign out_xfer  = out_valid & out_ready;

    // Reloading on the final byte's transfer keeps the byte stream gapless.
    assign in_ready = ~reset & ((state_q == IDLE) |
                                ((state_q == BUSY) & fin & out_ready));
    assign in_xfer  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        shreg_q <= data_in;
                        last_q  <= in_last;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (out_xfer) begin
                        if (!fin) begin
                            shreg_q <= shreg_q << 8;
                            cnt_q   <= cnt_q + 1'b1;
                        end else if (in_xfer) begin
                            shreg_q <= data_in;
                            last_q  <= in_last;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Scoreboard bench for word_to_byte_serializer at WIDTH=32 and WIDTH=8.
// Accepted words expand into expected byte queues; a negedge monitor checks.
module tb_word_to_byte_serializer;
    typedef struct packed {
        logic [7:0] b;
        logic       l;
        logic       e;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        was_rst = 1'b0;
    logic [31:0] din32;
    logic        iv32, il32, ir32, ov32, ol32, or32;
    logic [7:0]  do32;
    logic [7:0]  din8;
    logic        iv8, il8, ir8, ov8, ol8, or8;
    logic [7:0]  do8;
    int          tests = 0;
    int          fails = 0;
    bit          done;
    ent_t        q[2][$];

    always #5 clk = ~clk;

    word_to_byte_serializer #(.WIDTH(32)) u32 (
        .clk(clk), .reset(rst), .data_in(din32), .in_valid(iv32),
        .in_last(il32), .in_ready(ir32), .data_out(do32),
        .out_valid(ov32), .out_last(ol32), .out_ready(or32)
    );

    word_to_byte_serializer #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst), .data_in(din8), .in_valid(iv8),
        .in_last(il8), .in_ready(ir8), .data_out(do8),
        .out_valid(ov8), .out_last(ol8), .out_ready(or8)
    );

    task automatic mon(input int k, input int nb, input logic rn,
                       input logic wr, input logic iv, input logic il,
                       input logic [31:0] din, input logic ir,
                       input logic ov, input logic ol,
                       input logic [7:0] dout, input logic ordy);
        logic exp_ir;
        ent_t h;
        if (rn) begin
            tests++;
            if (ir !== 1'b0) begin
                fails++;
                $display("FAIL rst_in_ready[%0d] got %b want 0", k, ir);
            end
            if (wr) begin
                tests++;
                if (ov !== 1'b0 || ol !== 1'b0 || dout !== 8'h00) begin
                    fails++;
                    $display("FAIL rst_outs[%0d] got v=%b l=%b d=%h want 0 0 00",
                             k, ov, ol, dout);
                end
            end
            q[k].delete();
            return;
        end
        exp_ir = !ov || (q[k].size() > 0 && q[k][0].e && ordy);
        tests++;
        if (ir !== exp_ir) begin
            fails++;
            $display("FAIL in_ready[%0d] got %b want %b", k, ir, exp_ir);
        end
        if (ov === 1'b1) begin
            tests++;
            if (q[k].size() == 0) begin
                fails++;
                $display("FAIL spurious[%0d] got byte %h want none", k, dout);
            end else begin
                h = q[k][0];
                if (dout !== h.b || ol !== h.l) begin
                    fails++;
                    $display("FAIL byte[%0d] got %h/%b want %h/%b",
                             k, dout, ol, h.b, h.l);
                end
                if (ordy) void'(q[k].pop_front());
            end
        end
        if (iv && ir) begin
            for (int b = 0; b < nb; b++) begin
                h.b = 8'(din >> (8 * (nb - 1 - b)));
                h.l = il && (b == nb - 1);
                h.e = (b == nb - 1);
                q[k].push_back(h);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, 4, rst, was_rst, iv32, il32, din32, ir32, ov32, ol32, do32, or32);
        mon(1, 1, rst, was_rst, iv8, il8, {24'h0, din8}, ir8, ov8, ol8, do8, or8);
        was_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] w, input logic l);
        din32 = w;
        il32  = l;
        iv32  = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ir32) begin
                tick();
                iv32 = 1'b0;
                return;
            end
            tick();
        end
        iv32 = 1'b0;
        tests++;
        fails++;
        $display("FAIL send32_timeout got no in_ready want accept %h", w);
    endtask

    task automatic send8(input logic [7:0] w, input logic l);
        din8 = w;
        il8  = l;
        iv8  = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ir8) begin
                tick();
                iv8 = 1'b0;
                return;
            end
            tick();
        end
        iv8 = 1'b0;
        tests++;
        fails++;
        $display("FAIL send8_timeout got no in_ready want accept %h", w);
    endtask

    initial begin
        rst   = 1'b1;
        iv32  = 1'b1;
        din32 = 32'h99887766;
        il32  = 1'b1;
        or32  = 1'b1;
        iv8   = 1'b1;
        din8  = 8'h3C;
        il8   = 1'b1;
        or8   = 1'b1;
        repeat (2) tick();
        rst  = 1'b0;
        iv32 = 1'b0;
        iv8  = 1'b0;
        repeat (4) tick();

        send32(32'h11223344, 1'b1);
        repeat (6) tick();

        send32(32'hAABBCCDD, 1'b0);
        send32(32'h01020304, 1'b1);
        repeat (6) tick();

        send32(32'hDEADBEEF, 1'b1);
        tick();
        or32 = 1'b0;
        repeat (3) tick();
        or32 = 1'b1;
        repeat (4) tick();

        send32(32'hCAFEF00D, 1'b1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send32(32'h55667788, 1'b1);
        repeat (6) tick();

        send8(8'h5A, 1'b0);
        send8(8'hA5, 1'b1);
        repeat (3) tick();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send32($urandom, 1'($urandom_range(0, 1)));
                end
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 1)) tick();
                    send8(8'($urandom), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    or32 = ($urandom_range(0, 3) != 0);
                    or8  = ($urandom_range(0, 2) != 0);
                    tick();
                end
                or32 = 1'b1;
                or8  = 1'b1;
            end
        join

        for (int n = 0; n < 500; n++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && !ov32 && !ov8) break;
            tick();
        end
        repeat (2) tick();
        tests++;
        if (q[0].size() != 0) begin
            fails++;
            $display("FAIL drain32 got %0d left want 0", q[0].size());
        end
        tests++;
        if (q[1].size() != 0) begin
            fails++;
            $display("FAIL drain8 got %0d left want 0", q[1].size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
